// File: rtl/multdiv_ctrl.sv
// Sequences the shared iterative mul/div unit: stalls decode from detection until the one-cycle writeback.
// Latency: md_rdy accepted in BUSY gives WB next cycle; optional watchdog abort enabled by `define MD_TIMEOUT_EN.
module multdiv_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             insn_valid,
  input  logic [4:0]       opcode,
  input  logic [4:0]       aluOp,
  input  logic [4:0]       rd,
  input  logic             md_rdy,
  input  logic             md_exc,
  output logic             stall,
  output logic             md_start,
  output logic             md_is_div,
  output logic             md_abort,
  output logic             wb_en,
  output logic [4:0]       wb_reg,
  output logic             wb_use_status,
  output logic [31:0]      wb_status,
  output logic [CNT_W-1:0] busy_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

`ifdef MD_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0] r_state;
  logic [4:0] r_rd;
  logic       r_div;
  logic       r_exc;
  logic       r_tmo;
  logic       r_first;

  logic       w_md_op;
  logic       w_rdy_acc;
  logic       w_timeout;

  assign w_md_op   = ~reset & insn_valid & (opcode == 5'b00000) &
                     ((aluOp == 5'b00110) | (aluOp == 5'b00111));
  // The unit cannot answer in its own start cycle, so a pulse there is stale.
  assign w_rdy_acc = (r_state == S_BUSY) & ~r_first & md_rdy;
  assign w_timeout = TMO_EN & (r_state == S_BUSY) & ~w_rdy_acc & (busy_cnt == TMO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rd     <= 5'd0;
      r_div    <= 1'b0;
      r_exc    <= 1'b0;
      r_tmo    <= 1'b0;
      r_first  <= 1'b0;
      busy_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_md_op) begin
            r_rd     <= rd;
            r_div    <= aluOp[0];
            r_exc    <= 1'b0;
            r_tmo    <= 1'b0;
            r_first  <= 1'b1;
            busy_cnt <= '0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_first <= 1'b0;
          if (busy_cnt != {CNT_W{1'b1}}) begin
            busy_cnt <= busy_cnt + CNT_W'(1);
          end
          if (w_rdy_acc) begin
            r_exc   <= md_exc;
            r_state <= S_WB;
          end else if (w_timeout) begin
            r_exc   <= 1'b1;
            r_tmo   <= 1'b1;
            r_state <= S_WB;
          end
        end
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall         = 1'b0;
    md_start      = 1'b0;
    md_is_div     = 1'b0;
    md_abort      = 1'b0;
    wb_en         = 1'b0;
    wb_reg        = 5'd0;
    wb_use_status = 1'b0;
    wb_status     = 32'd0;
    case (r_state)
      S_IDLE: stall = w_md_op;
      S_BUSY: begin
        stall     = 1'b1;
        md_start  = r_first;
        md_is_div = r_div;
        md_abort  = w_timeout;
      end
      S_WB: begin
        md_is_div = r_div;
        if (r_exc) begin
          wb_en         = 1'b1;
          wb_reg        = 5'd30;
          wb_use_status = 1'b1;
          wb_status     = r_tmo ? 32'd6 : (r_div ? 32'd5 : 32'd4);
        end else begin
          wb_en  = |r_rd;
          wb_reg = r_rd;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus pushes expected writebacks, a monitor pops them on wb_en.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        insn_valid;
  logic [4:0]  opcode;
  logic [4:0]  aluOp;
  logic [4:0]  rd;
  logic        md_rdy;
  logic        md_exc;
  logic        stall;
  logic        md_start;
  logic        md_is_div;
  logic        md_abort;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic        wb_use_status;
  logic [31:0] wb_status;
  logic [5:0]  busy_cnt;

  typedef struct {
    logic [4:0]  reg_a;
    logic        use_st;
    logic [31:0] st;
  } wb_t;

  wb_t exp_q[$];
  int  checks    = 0;
  int  errors    = 0;
  int  n_start   = 0;
  int  exp_start = 0;

  multdiv_ctrl #(.TIMEOUT(40), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .insn_valid(insn_valid), .opcode(opcode),
    .aluOp(aluOp), .rd(rd), .md_rdy(md_rdy), .md_exc(md_exc), .stall(stall),
    .md_start(md_start), .md_is_div(md_is_div), .md_abort(md_abort), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_use_status(wb_use_status), .wb_status(wb_status),
    .busy_cnt(busy_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wb(input logic [4:0] r, input logic us, input logic [31:0] st);
    wb_t e;
    e.reg_a  = r;
    e.use_st = us;
    e.st     = st;
    exp_q.push_back(e);
  endtask

  // Monitor: samples away from the rising edge, after stimulus has settled.
  always @(negedge clock) begin : monitor
    wb_t e;
    #2;
    if (md_start === 1'b1) n_start++;
    if (wb_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got write to reg %0d expected no writeback", wb_reg);
      end else begin
        e = exp_q.pop_front();
        chk("wb_reg", {27'd0, wb_reg}, {27'd0, e.reg_a});
        chk("wb_use_status", {31'd0, wb_use_status}, {31'd0, e.use_st});
        chk("wb_status", wb_status, e.st);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      insn_valid = 1'b0; md_rdy = 1'b0; md_exc = 1'b0;
      #1;
      chk("idle_stall", {31'd0, stall}, 32'd0);
      chk("idle_start", {31'd0, md_start}, 32'd0);
    end
  endtask

  // delay: BUSY cycles after the start cycle until the accepted md_rdy.
  task automatic run_op(input bit is_div, input logic [4:0] rdv, input int delay,
                        input bit exc, input bit early, input int exp_busy);
    @(negedge clock);
    insn_valid = 1'b1; opcode = 5'd0; aluOp = is_div ? 5'd7 : 5'd6; rd = rdv;
    md_rdy = 1'b0; md_exc = 1'b0;
    #1;
    chk("stall_T", {31'd0, stall}, 32'd1);
    chk("start_T", {31'd0, md_start}, 32'd0);
    exp_start++;
    if (exc) push_wb(5'd30, 1'b1, is_div ? 32'd5 : 32'd4);
    else if (rdv != 5'd0) push_wb(rdv, 1'b0, 32'd0);
    @(negedge clock);
    md_rdy = early; md_exc = exc;
    #1;
    chk("start_T1", {31'd0, md_start}, 32'd1);
    chk("stall_T1", {31'd0, stall}, 32'd1);
    chk("is_div_T1", {31'd0, md_is_div}, {31'd0, is_div});
    for (int k = 1; k <= delay; k++) begin
      @(negedge clock);
      md_rdy = (k == delay); md_exc = exc;
      #1;
      chk("start_busy", {31'd0, md_start}, 32'd0);
      chk("stall_busy", {31'd0, stall}, 32'd1);
      chk("is_div_busy", {31'd0, md_is_div}, {31'd0, is_div});
    end
    @(negedge clock);
    md_rdy = 1'b0; md_exc = 1'b0;
    #1;
    chk("stall_wb", {31'd0, stall}, 32'd0);
    chk("busy_cnt_wb", {26'd0, busy_cnt}, exp_busy);
    chk("is_div_wb", {31'd0, md_is_div}, {31'd0, is_div});
    if (!exc && rdv == 5'd0) chk("wb_en_rd0", {31'd0, wb_en}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1; insn_valid = 1'b0; opcode = 5'd0; aluOp = 5'd0; rd = 5'd0;
    md_rdy = 1'b0; md_exc = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_start", {31'd0, md_start}, 32'd0);
    chk("rst_is_div", {31'd0, md_is_div}, 32'd0);
    chk("rst_abort", {31'd0, md_abort}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_status", wb_status, 32'd0);
    chk("rst_busy_cnt", {26'd0, busy_cnt}, 32'd0);

    // Non-md instructions must not stall.
    @(negedge clock);
    insn_valid = 1'b1; opcode = 5'd0; aluOp = 5'b00101; rd = 5'd4;
    #1; chk("nonmd_alu", {31'd0, stall}, 32'd0);
    @(negedge clock);
    opcode = 5'd1; aluOp = 5'b00110;
    #1; chk("nonmd_opc", {31'd0, stall}, 32'd0);
    idle(1);

    run_op(1'b0, 5'd5, 32, 1'b0, 1'b0, 33);   // long mul
    idle(2);
    run_op(1'b1, 5'd7, 4, 1'b1, 1'b0, 5);     // div by zero
    idle(1);
    run_op(1'b0, 5'd0, 2, 1'b0, 1'b0, 3);     // rd=0, no write
    idle(1);
    run_op(1'b0, 5'd9, 1, 1'b1, 1'b0, 2);     // mul overflow
    idle(1);
    run_op(1'b0, 5'd12, 3, 1'b0, 1'b1, 4);    // stale rdy in start cycle
    idle(1);

    // md_rdy in IDLE is ignored.
    @(negedge clock);
    md_rdy = 1'b1; md_exc = 1'b1;
    #1; chk("idle_rdy_stall", {31'd0, stall}, 32'd0);
    idle(1);

    run_op(1'b0, 5'd3, 2, 1'b0, 1'b0, 3);     // back-to-back pair
    run_op(1'b0, 5'd4, 2, 1'b0, 1'b0, 3);
    idle(1);

    // Reset in BUSY drops the operation.
    @(negedge clock);
    insn_valid = 1'b1; opcode = 5'd0; aluOp = 5'd7; rd = 5'd8;
    exp_start++;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; insn_valid = 1'b0;
    #1;
    chk("rb_stall", {31'd0, stall}, 32'd0);
    chk("rb_start", {31'd0, md_start}, 32'd0);
    chk("rb_is_div", {31'd0, md_is_div}, 32'd0);
    chk("rb_abort", {31'd0, md_abort}, 32'd0);
    chk("rb_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rb_wb_reg", {27'd0, wb_reg}, 32'd0);
    chk("rb_busy_cnt", {26'd0, busy_cnt}, 32'd0);
    @(negedge clock);
    md_rdy = 1'b1;
    #1; chk("rb_late_rdy", {31'd0, wb_en}, 32'd0);
    idle(1);

    // md_rdy never arrives.
    @(negedge clock);
    insn_valid = 1'b1; opcode = 5'd0; aluOp = 5'd6; rd = 5'd3; md_rdy = 1'b0;
    exp_start++;
`ifdef MD_TIMEOUT_EN
    push_wb(5'd30, 1'b1, 32'd6);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      #1;
      chk("tmo_stall", {31'd0, stall}, 32'd1);
      chk("tmo_abort", {31'd0, md_abort}, (n == 40) ? 32'd1 : 32'd0);
    end
    @(negedge clock);
    #1;
    chk("tmo_wb_stall", {31'd0, stall}, 32'd0);
    chk("tmo_wb_abort", {31'd0, md_abort}, 32'd0);
`else
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      #1;
      chk("wait_stall", {31'd0, stall}, 32'd1);
      chk("wait_abort", {31'd0, md_abort}, 32'd0);
    end
    chk("wait_busy_sat", {26'd0, busy_cnt}, 32'd63);
    push_wb(5'd3, 1'b0, 32'd0);
    @(negedge clock);
    md_rdy = 1'b1;
    @(negedge clock);
    md_rdy = 1'b0;
    #1;
    chk("wait_wb_stall", {31'd0, stall}, 32'd0);
`endif
    idle(3);

    chk("queue_empty", exp_q.size(), 32'd0);
    chk("start_pulses", n_start, exp_start);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
